// File: rtl/serial_paralelo_sync.sv
// rtl/serial_paralelo_sync.sv - serial-to-parallel receiver with COM-symbol byte alignment and lock
module serial_paralelo_sync #(
    parameter logic [7:0] COM        = 8'hBC,
    parameter int         SYNC_COUNT = 4
) (
    input  logic       clk32f,
    input  logic       reset,
    input  logic       data_in,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       active,
    output logic       byte_strobe
);

    localparam logic [3:0] SYNC_CNT = 4'(SYNC_COUNT);

    typedef enum logic [1:0] {
        ST_SEARCH,
        ST_ALIGN,
        ST_ACTIVE
    } state_t;

    state_t      state_q, state_d;
    logic [6:0]  sr_q, sr_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [3:0]  com_cnt_q, com_cnt_d;
    logic [7:0]  data_q, data_d;
    logic        valid_q, valid_d;
    logic        active_q, active_d;
    logic        strobe_q, strobe_d;
    logic [7:0]  win;
    logic        boundary;
    logic        is_com;

    assign win      = {sr_q, data_in};
    assign boundary = (cnt_q == 3'd7);
    assign is_com   = (win == COM);

    always_comb begin
        state_d   = state_q;
        sr_d      = win[6:0];
        cnt_d     = (state_q == ST_SEARCH) ? 3'd0 : cnt_q + 3'd1;
        com_cnt_d = com_cnt_q;
        data_d    = data_q;
        valid_d   = valid_q;
        active_d  = active_q;
        strobe_d  = 1'b0;

        unique case (state_q)
            ST_SEARCH: begin
                // A match at any bit offset is provisionally accepted; ALIGN weeds out false ones.
                if (is_com) begin
                    cnt_d     = 3'd0;
                    com_cnt_d = 4'd1;
                    if (SYNC_CNT == 4'd1) begin
                        state_d  = ST_ACTIVE;
                        active_d = 1'b1;
                    end else begin
                        state_d = ST_ALIGN;
                    end
                end
            end
            ST_ALIGN: begin
                if (boundary) begin
                    if (is_com) begin
                        com_cnt_d = com_cnt_q + 4'd1;
                        if (com_cnt_q + 4'd1 == SYNC_CNT) begin
                            state_d  = ST_ACTIVE;
                            active_d = 1'b1;
                        end
                    end else begin
                        com_cnt_d = 4'd0;
                        state_d   = ST_SEARCH;
                    end
                end
            end
            ST_ACTIVE: begin
                // Lock is sticky: only reset leaves this state.
                if (boundary) begin
                    data_d   = win;
                    valid_d  = !is_com;
                    strobe_d = 1'b1;
                end
            end
            default: state_d = ST_SEARCH;
        endcase
    end

    always_ff @(posedge clk32f or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_SEARCH;
            sr_q      <= 7'd0;
            cnt_q     <= 3'd0;
            com_cnt_q <= 4'd0;
            data_q    <= 8'h00;
            valid_q   <= 1'b0;
            active_q  <= 1'b0;
            strobe_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            sr_q      <= sr_d;
            cnt_q     <= cnt_d;
            com_cnt_q <= com_cnt_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            active_q  <= active_d;
            strobe_q  <= strobe_d;
        end
    end

    assign data_out    = data_q;
    assign valid_out   = valid_q;
    assign active      = active_q;
    assign byte_strobe = strobe_q;

endmodule

// File: tb/tb_serial_paralelo_sync.sv
// tb/tb_serial_paralelo_sync.sv - self-checking bench for serial_paralelo_sync
module tb_serial_paralelo_sync;

    localparam logic [7:0] COM = 8'hBC;
    localparam int         SC  = 4;

    logic       clk32f = 1'b0;
    logic       reset  = 1'b0;
    logic       data_in = 1'b0;
    logic [7:0] data_out;
    logic       valid_out;
    logic       active;
    logic       byte_strobe;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: bit history plus absolute edge index of the alignment anchor.
    int m_mode;      // 0 hunting, 1 confirming, 2 locked
    int m_hist;
    int m_edge;
    int m_anchor;
    int m_coms;
    int m_data;
    int m_valid;
    int m_active;
    int m_strobe;

    serial_paralelo_sync #(.COM(COM), .SYNC_COUNT(SC)) dut (
        .clk32f      (clk32f),
        .reset       (reset),
        .data_in     (data_in),
        .data_out    (data_out),
        .valid_out   (valid_out),
        .active      (active),
        .byte_strobe (byte_strobe)
    );

    always #5 clk32f = ~clk32f;

    task automatic model_reset();
        m_mode = 0; m_hist = 0; m_edge = 0; m_anchor = 0; m_coms = 0;
        m_data = 0; m_valid = 0; m_active = 0; m_strobe = 0;
    endtask

    task automatic model_step(input logic b);
        int win;
        bit on_byte;
        m_hist = ((m_hist << 1) | int'(b)) & 255;
        win = m_hist;
        m_edge++;
        m_strobe = 0;
        on_byte = (m_edge > m_anchor) && (((m_edge - m_anchor) % 8) == 0);
        if (m_mode == 0) begin
            if (win == int'(COM)) begin
                m_anchor = m_edge;
                m_coms = 1;
                if (SC == 1) begin m_mode = 2; m_active = 1; end
                else m_mode = 1;
            end
        end else if (m_mode == 1) begin
            if (on_byte) begin
                if (win == int'(COM)) begin
                    m_coms++;
                    if (m_coms == SC) begin m_mode = 2; m_active = 1; end
                end else begin
                    m_mode = 0;
                    m_coms = 0;
                end
            end
        end else if (on_byte) begin
            m_data = win;
            m_valid = (win != int'(COM)) ? 1 : 0;
            m_strobe = 1;
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("data_out", data_out, 8'(m_data));
        chk("valid_out", {7'd0, valid_out}, 8'(m_valid));
        chk("active", {7'd0, active}, 8'(m_active));
        chk("byte_strobe", {7'd0, byte_strobe}, 8'(m_strobe));
    endtask

    task automatic send_bit(input logic b);
        @(negedge clk32f);
        data_in = b;
        @(posedge clk32f);
        if (reset) model_step(b);
        else model_reset();
        #1;
        check_all();
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) send_bit(v[i]);
    endtask

    task automatic do_reset();
        @(negedge clk32f);
        reset = 1'b0;
        #1;
        model_reset();
        check_all();
        send_bit(1'b0);
        send_bit(1'b1);
        @(negedge clk32f);
        reset = 1'b1;
    endtask

    task automatic send_random_bytes(input int n);
        logic [7:0] v;
        for (int i = 0; i < n; i++) begin
            v = ($urandom_range(0, 3) == 0) ? COM : 8'($urandom);
            send_byte(v);
        end
    endtask

    initial begin
        model_reset();
        // Reset state
        do_reset();

        // Lock with three bits of offset, then two data bytes
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        for (int i = 0; i < 4; i++) send_byte(COM);
        chk("lock_active", {7'd0, active}, 8'd1);
        chk("lock_no_strobe", {7'd0, byte_strobe}, 8'd0);
        send_byte(8'h12);
        chk("first_byte", data_out, 8'h12);
        send_byte(8'h34);
        chk("second_byte", data_out, 8'h34);

        // Idle symbol in the locked stream
        send_byte(8'hA1);
        send_byte(COM);
        chk("idle_valid", {7'd0, valid_out}, 8'd0);
        send_byte(8'h7F);

        // Sticky lock through an all-zero stream
        for (int i = 0; i < 8; i++) send_byte(8'h00);
        chk("sticky_active", {7'd0, active}, 8'd1);

        // Asynchronous reset mid-byte while holding 8'h3A
        send_byte(8'h3A);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        chk("pre_reset_data", data_out, 8'h3A);
        @(negedge clk32f);
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        check_all();
        send_bit(1'b1);
        @(negedge clk32f);
        reset = 1'b1;

        // Incomplete sync, then a clean lock
        for (int i = 0; i < 3; i++) send_byte(COM);
        send_byte(8'h55);
        chk("incomplete_active", {7'd0, active}, 8'd0);
        for (int i = 0; i < 4; i++) send_byte(COM);
        chk("relock_active", {7'd0, active}, 8'd1);
        send_random_bytes(6);

        // Misaligned COM rejected at the next boundary, then a proper lock
        do_reset();
        send_byte(8'h0B);
        send_byte(8'hC3);
        send_byte(8'h55);
        chk("misaligned_active", {7'd0, active}, 8'd0);
        for (int i = 0; i < 4; i++) send_byte(COM);
        chk("post_misalign_active", {7'd0, active}, 8'd1);
        send_random_bytes(10);

        // Random bit noise in the hunt phase, then random locked traffic
        for (int r = 0; r < 4; r++) begin
            do_reset();
            for (int i = 0; i < 120; i++) send_bit(1'($urandom));
            for (int i = 0; i < 4; i++) send_byte(COM);
            send_random_bytes(12);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
